// File: rtl/dispatch_sequencer.sv
// Micro-sequencer with register-based dispatch tables: next/fetch/jump/dispatch
// selection of the micro-PC, a one-cycle dispatch hit pulse and a sticky illegal flag.
module dispatch_sequencer #(
    parameter int UADDR_W = 5,
    parameter int DT_DEPTH = 8,
    parameter int NUM_DT = 2,
    parameter logic [UADDR_W-1:0] TRAP_ADDR = {UADDR_W{1'b1}},
    localparam int DTS_W = (NUM_DT > 1) ? $clog2(NUM_DT) : 1,
    localparam int IDX_W = (DT_DEPTH > 1) ? $clog2(DT_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [1:0]         seq_mode,
    input  logic [DTS_W-1:0]   seq_dt,
    input  logic [UADDR_W-1:0] jump_addr,
    input  logic               stall,
    input  logic               wr_en,
    input  logic [DTS_W-1:0]   wr_dt,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_valid,
    input  logic [5:0]         wr_opcode,
    input  logic [5:0]         wr_funct,
    input  logic               wr_fcare,
    input  logic [UADDR_W-1:0] wr_target,
    output logic [UADDR_W-1:0] upc,
    output logic               dispatch_hit,
    output logic               illegal
);

    logic               r_valid  [NUM_DT][DT_DEPTH];
    logic [5:0]         r_opcode [NUM_DT][DT_DEPTH];
    logic [5:0]         r_funct  [NUM_DT][DT_DEPTH];
    logic               r_fcare  [NUM_DT][DT_DEPTH];
    logic [UADDR_W-1:0] r_target [NUM_DT][DT_DEPTH];

    logic [UADDR_W-1:0] r_upc;
    logic               r_hit;
    logic               r_illegal;

    logic               w_dt_ok;
    logic [DTS_W-1:0]   w_dt_sel;
    logic               w_wr_ok;
    logic [DT_DEPTH-1:0] w_match;
    logic               w_any;
    logic [UADDR_W-1:0] w_target;
    logic [UADDR_W-1:0] w_upc_nxt;
    logic               w_hit_nxt;
    logic               w_ill_nxt;

    assign w_dt_ok  = (32'(seq_dt) < NUM_DT);
    assign w_dt_sel = w_dt_ok ? seq_dt : {DTS_W{1'b0}};
    assign w_wr_ok  = wr_en && (32'(wr_dt) < NUM_DT) && (32'(wr_idx) < DT_DEPTH);

    // Table lookup; descending scan lets the lowest matching index win.
    always_comb begin
        w_match  = {DT_DEPTH{1'b0}};
        w_target = {UADDR_W{1'b0}};
        for (int i = DT_DEPTH - 1; i >= 0; i--) begin
            w_match[i] = w_dt_ok && r_valid[w_dt_sel][i]
                         && (r_opcode[w_dt_sel][i] == opcode)
                         && (!r_fcare[w_dt_sel][i] || (r_funct[w_dt_sel][i] == funct));
            w_target   = w_match[i] ? r_target[w_dt_sel][i] : w_target;
        end
        w_any = |w_match;
    end

    // Next micro-PC, hit pulse and illegal flag selection.
    always_comb begin
        w_upc_nxt = r_upc;
        w_hit_nxt = 1'b0;
        w_ill_nxt = r_illegal;
        if (!stall) begin
            case (seq_mode)
                2'b00: w_upc_nxt = r_upc + {{(UADDR_W-1){1'b0}}, 1'b1};
                2'b01: begin
                    if (w_any) begin
                        w_upc_nxt = w_target;
                        w_hit_nxt = 1'b1;
                    end else begin
                        w_upc_nxt = TRAP_ADDR;
                        w_ill_nxt = 1'b1;
                    end
                end
                2'b10: begin
                    w_upc_nxt = {UADDR_W{1'b0}};
                    w_ill_nxt = 1'b0;
                end
                2'b11: w_upc_nxt = jump_addr;
                default: w_upc_nxt = r_upc;
            endcase
        end else begin
            w_upc_nxt = r_upc;
            w_hit_nxt = 1'b0;
            w_ill_nxt = r_illegal;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upc     <= {UADDR_W{1'b0}};
            r_hit     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_upc     <= w_upc_nxt;
            r_hit     <= w_hit_nxt;
            r_illegal <= w_ill_nxt;
        end
    end

    // Entry valid bits; the only table state that reset must clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_DT; t++) begin
                for (int i = 0; i < DT_DEPTH; i++) begin
                    r_valid[t][i] <= 1'b0;
                end
            end
        end else if (w_wr_ok) begin
            r_valid[wr_dt][wr_idx] <= wr_valid;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Entry payload fields; contents are don't-care while the entry is invalid.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ok) begin
            r_opcode[wr_dt][wr_idx] <= wr_opcode;
            r_funct[wr_dt][wr_idx]  <= wr_funct;
            r_fcare[wr_dt][wr_idx]  <= wr_fcare;
            r_target[wr_dt][wr_idx] <= wr_target;
        end else begin
            r_opcode <= r_opcode;
            r_funct  <= r_funct;
            r_fcare  <= r_fcare;
            r_target <= r_target;
        end
    end

    assign upc          = r_upc;
    assign dispatch_hit = r_hit;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Scoreboard bench for dispatch_sequencer: directed scenarios then random traffic,
// checked against a table-lookup reference model.
module tb_dispatch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic [1:0] seq_mode;
    logic [0:0] seq_dt;
    logic [4:0] jump_addr;
    logic       stall;
    logic       wr_en;
    logic [0:0] wr_dt;
    logic [2:0] wr_idx;
    logic       wr_valid;
    logic [5:0] wr_opcode, wr_funct;
    logic       wr_fcare;
    logic [4:0] wr_target;
    logic [4:0] upc;
    logic       dispatch_hit, illegal;

    dispatch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .seq_mode(seq_mode), .seq_dt(seq_dt), .jump_addr(jump_addr), .stall(stall),
        .wr_en(wr_en), .wr_dt(wr_dt), .wr_idx(wr_idx), .wr_valid(wr_valid),
        .wr_opcode(wr_opcode), .wr_funct(wr_funct), .wr_fcare(wr_fcare),
        .wr_target(wr_target), .upc(upc), .dispatch_hit(dispatch_hit), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [1:0] mode;
        logic [0:0] dt;
        logic [4:0] jaddr;
        logic       stall;
        logic [5:0] op, fn;
        logic       wr_en;
        logic [0:0] wr_dt;
        logic [2:0] wr_idx;
        logic       wr_valid;
        logic [5:0] wr_op, wr_fn;
        logic       wr_fcare;
        logic [4:0] wr_tgt;
    } stim_t;

    typedef struct {
        logic [4:0] upc;
        logic       hit;
        logic       ill;
        string      name;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model state
    bit       m_valid [2][8];
    bit [5:0] m_op    [2][8];
    bit [5:0] m_fn    [2][8];
    bit       m_fc    [2][8];
    bit [4:0] m_tgt   [2][8];
    int       m_upc;
    bit       m_ill;

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.mode = 2'b00; s.dt = 1'b0; s.jaddr = 5'd0; s.stall = 1'b0;
        s.op = 6'd0; s.fn = 6'd0; s.wr_en = 1'b0; s.wr_dt = 1'b0; s.wr_idx = 3'd0;
        s.wr_valid = 1'b0; s.wr_op = 6'd0; s.wr_fn = 6'd0; s.wr_fcare = 1'b0; s.wr_tgt = 5'd0;
        return s;
    endfunction

    task automatic step(input stim_t s, input string name);
        exp_t e;
        bit   found = 0;
        int   tgt = 0;
        rst_n = s.rst_n; seq_mode = s.mode; seq_dt = s.dt; jump_addr = s.jaddr;
        stall = s.stall; opcode = s.op; funct = s.fn; wr_en = s.wr_en; wr_dt = s.wr_dt;
        wr_idx = s.wr_idx; wr_valid = s.wr_valid; wr_opcode = s.wr_op; wr_funct = s.wr_fn;
        wr_fcare = s.wr_fcare; wr_target = s.wr_tgt;
        e.hit = 1'b0;
        if (!s.rst_n) begin
            m_upc = 0; m_ill = 0;
            foreach (m_valid[t, i]) m_valid[t][i] = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (!found && m_valid[s.dt][i] && m_op[s.dt][i] == s.op &&
                    (!m_fc[s.dt][i] || m_fn[s.dt][i] == s.fn)) begin
                    found = 1; tgt = m_tgt[s.dt][i];
                end
            if (!s.stall) begin
                case (s.mode)
                    2'b00: m_upc = (m_upc + 1) % 32;
                    2'b01: if (found) begin m_upc = tgt; e.hit = 1'b1; end
                           else begin m_upc = 31; m_ill = 1; end
                    2'b10: begin m_upc = 0; m_ill = 0; end
                    default: m_upc = s.jaddr;
                endcase
            end
            if (s.wr_en) begin
                m_valid[s.wr_dt][s.wr_idx] = s.wr_valid;
                m_op[s.wr_dt][s.wr_idx]    = s.wr_op;
                m_fn[s.wr_dt][s.wr_idx]    = s.wr_fn;
                m_fc[s.wr_dt][s.wr_idx]    = s.wr_fcare;
                m_tgt[s.wr_dt][s.wr_idx]   = s.wr_tgt;
            end
        end
        e.upc = 5'(m_upc); e.ill = m_ill; e.name = name;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wr(input bit [0:0] dt, input bit [2:0] idx, input bit [5:0] op,
                      input bit [5:0] fn, input bit fc, input bit [4:0] tgt, input string name);
        stim_t s = idle();
        s.mode = 2'b10;
        s.wr_en = 1'b1; s.wr_dt = dt; s.wr_idx = idx; s.wr_valid = 1'b1;
        s.wr_op = op; s.wr_fn = fn; s.wr_fcare = fc; s.wr_tgt = tgt;
        step(s, name);
    endtask

    task automatic disp(input bit [5:0] op, input bit [5:0] fn, input string name);
        stim_t s = idle();
        s.mode = 2'b01; s.dt = 1'b1; s.op = op; s.fn = fn;
        step(s, name);
    endtask

    function automatic logic [5:0] pick(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        case ($urandom_range(0, 3))
            0: return a;
            1: return b;
            2: return c;
            default: return 6'($urandom);
        endcase
    endfunction

    // Monitor: compares the DUT outputs one cycle after each issued vector.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (upc !== e.upc || dispatch_hit !== e.hit || illegal !== e.ill) begin
                miscompares++;
                $display("FAIL %s: got upc=%0d hit=%0b illegal=%0b, expected upc=%0d hit=%0b illegal=%0b",
                         e.name, upc, dispatch_hit, illegal, e.upc, e.hit, e.ill);
            end
        end
    end

    initial begin
        stim_t s;
        @(negedge clk);
        s = idle(); s.rst_n = 1'b0;
        step(s, "reset");
        disp(6'b000000, 6'b011000, "miss_after_reset");
        wr(1'b1, 3'd0, 6'b000000, 6'b011000, 1'b1, 5'd17, "wr_idx0");
        wr(1'b1, 3'd1, 6'b011100, 6'b000000, 1'b1, 5'd22, "wr_idx1");
        wr(1'b1, 3'd2, 6'b011100, 6'b000100, 1'b1, 5'd23, "wr_idx2");
        disp(6'b000000, 6'b011000, "disp_mul");
        disp(6'b011100, 6'b000000, "disp_madd");
        disp(6'b011100, 6'b000100, "disp_msub");
        wr(1'b1, 3'd3, 6'b011100, 6'b101010, 1'b0, 5'd9, "wr_idx3");
        disp(6'b011100, 6'b000100, "prio_idx2");
        disp(6'b011100, 6'b111111, "dontcare_idx3");
        disp(6'b111111, 6'b000000, "miss_trap");
        s = idle();
        step(s, "next_wrap");
        s.mode = 2'b10;
        step(s, "fetch_clear");
        s = idle(); s.mode = 2'b11; s.jaddr = 5'd12;
        step(s, "jump");
        s = idle(); s.mode = 2'b01; s.dt = 1'b1; s.op = 6'b000000; s.fn = 6'b011000; s.stall = 1'b1;
        step(s, "stall_hold");
        s = idle(); s.mode = 2'b01; s.dt = 1'b1; s.op = 6'b000000; s.fn = 6'b011000;
        s.wr_en = 1'b1; s.wr_dt = 1'b1; s.wr_idx = 3'd0; s.wr_valid = 1'b1;
        s.wr_op = 6'b000000; s.wr_fn = 6'b011000; s.wr_fcare = 1'b1; s.wr_tgt = 5'd5;
        step(s, "collide_old");
        disp(6'b000000, 6'b011000, "collide_new");
        s = idle(); s.rst_n = 1'b0; s.mode = 2'b01; s.dt = 1'b1; s.op = 6'b000000; s.fn = 6'b011000;
        step(s, "reset_mid");
        disp(6'b000000, 6'b011000, "miss_post_reset");

        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.rst_n = ($urandom_range(0, 59) != 0);
            s.mode  = 2'($urandom);
            s.dt    = 1'($urandom);
            s.jaddr = 5'($urandom);
            s.stall = ($urandom_range(0, 7) == 0);
            s.op    = pick(6'h00, 6'h1c, 6'h3f);
            s.fn    = pick(6'h18, 6'h00, 6'h04);
            s.wr_en = ($urandom_range(0, 2) == 0);
            s.wr_dt = 1'($urandom);
            s.wr_idx = 3'($urandom);
            s.wr_valid = ($urandom_range(0, 4) != 0);
            s.wr_op  = pick(6'h00, 6'h1c, 6'h3f);
            s.wr_fn  = pick(6'h18, 6'h00, 6'h04);
            s.wr_fcare = 1'($urandom);
            s.wr_tgt = 5'($urandom);
            step(s, "random");
        end

        s = idle();
        rst_n = s.rst_n; stall = 1'b1; wr_en = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dispatch_sequencer.md
DISPATCH_SEQUENCER -- requirements
Module: dispatch_sequencer

Interface
REQ-001 The block SHALL take parameter UADDR_W, default 5, as the micro-address width.
REQ-002 The block SHALL take parameter DT_DEPTH, default 8, as the entries per dispatch table.
REQ-003 The block SHALL take parameter NUM_DT, default 2, as the number of dispatch tables.
REQ-004 The block SHALL take parameter TRAP_ADDR, default all-ones (5'h1F), as the micro-address entered on a dispatch miss.
REQ-005 The block SHALL define DTS_W = max(1, clog2(NUM_DT)) and IDX_W = max(1, clog2(DT_DEPTH)).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-008 The block SHALL have ports opcode and funct, each input, 6 bits: the instruction fields.
REQ-009 The block SHALL have port seq_mode, input, 2 bits: 00 next, 01 dispatch, 10 fetch, 11 jump.
REQ-010 The block SHALL have ports seq_dt (input, DTS_W), selecting the dispatch table, and jump_addr (input, UADDR_W), the jump target.
REQ-011 The block SHALL have port stall, input, 1 bit: hold the sequencer.
REQ-012 The block SHALL have write ports wr_en (1), wr_dt (DTS_W), wr_idx (IDX_W), wr_valid (1), wr_opcode (6), wr_funct (6), wr_fcare (1) and wr_target (UADDR_W), all inputs.
REQ-013 The block SHALL have outputs upc (UADDR_W), the current micro-address; dispatch_hit (1), a pulse; and illegal (1), a sticky flag.

Function
REQ-014 Each table entry SHALL hold {valid, opcode, funct, fcare, target}, stored in registers.
REQ-015 An entry SHALL match when valid=1, opcode equals the entry opcode, and either fcare=0 or funct equals the entry funct.
REQ-016 When several entries match, the lowest index in the selected table SHALL win.
REQ-017 A write with wr_en=1 SHALL update entry [wr_dt][wr_idx] at the clock edge; it is visible to lookups from the next cycle only.
REQ-018 A same-cycle write and dispatch to the same entry SHALL use the old contents.
REQ-019 A write with wr_dt >= NUM_DT SHALL be ignored.
REQ-020 Writes SHALL proceed regardless of stall.
REQ-021 With stall=1, upc and illegal SHALL hold, and dispatch_hit SHALL be 0 in the next cycle.
REQ-022 When not stalled, the next-upc SHALL be selected as follows:
- next: upc+1, wrapping from 2^UADDR_W-1 to 0;
- fetch: 0;
- jump: jump_addr;
- dispatch: target of the winning entry.
REQ-023 A dispatch hit SHALL set dispatch_hit=1 for exactly the following cycle; dispatch_hit SHALL be 0 otherwise.
REQ-024 A dispatch miss (no match, or seq_dt >= NUM_DT) SHALL load upc=TRAP_ADDR and set illegal=1.
REQ-025 illegal SHALL clear only on a non-stalled fetch; if the same cycle also misses, set wins (not possible by mode encoding, stated for completeness).
REQ-026 All outputs SHALL be registered; each lookup-to-upc has latency 1 cycle, and there are no combinational paths from inputs to outputs.

Reset
REQ-027 When rst_n=0 at a rising clk edge, the block SHALL set upc=0, dispatch_hit=0 and illegal=0, and clear every entry valid bit; other entry fields are don't-care.
REQ-028 Reset SHALL override stall, wr_en and seq_mode in the same cycle.
REQ-029 Reset asserted mid-sequence SHALL abandon any pending dispatch, with no residual hit pulse.
REQ-030 After reset release, all dispatches SHALL miss until the tables are written.

Verification
REQ-031 The bench SHALL cover a programmed dispatch. Load table 1: idx0 {000000, 011000, fcare=1, 17}, idx1 {011100, 000000, fcare=1, 22}, idx2 {011100, 000100, fcare=1, 23}. Then dispatch table 1 with mul, madd and msub in turn -> upc 17, 22, 23 in successive cycles, with dispatch_hit=1 each cycle.
REQ-032 The bench SHALL cover priority and don't-care matching. Load idx3 {011100, x, fcare=0, 9}; dispatch 011100/000100 -> upc=23 (idx2 wins); dispatch 011100/111111 -> upc=9.
REQ-033 The bench SHALL cover the miss and illegal lifecycle. Dispatch opcode 111111 -> upc=31, illegal=1; then next -> upc=0 (wrap), illegal still 1; then fetch -> upc=0, illegal=0.
REQ-034 The bench SHALL cover stall and write collision. Assert stall while in dispatch mode -> upc held, dispatch_hit=0. Same-cycle write of idx0 target=5 and dispatch of mul -> upc=17; a repeat dispatch of mul -> upc=5.
REQ-035 The bench SHALL cover reset mid-operation. Pulse rst_n=0 during a dispatch cycle -> upc=0, dispatch_hit=0, illegal=0; a subsequent mul dispatch -> miss, upc=31.
